// File: rtl/usb_audio_pkg.sv
// Shared definitions for the USB audio endpoint blocks: PIDs, token field layout
// and the IN packetizer state encoding.
package usb_audio_pkg;

    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_DATA0 = 8'hC3;

    localparam int unsigned TOK_PID_LSB  = 16;
    localparam int unsigned TOK_PID_W    = 8;
    localparam int unsigned TOK_ADDR_LSB = 9;
    localparam int unsigned TOK_ADDR_W   = 7;
    localparam int unsigned TOK_ENDP_LSB = 5;
    localparam int unsigned TOK_ENDP_W   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } pkt_state_e;

endpackage

// File: rtl/audio_word_fifo.sv
// Synchronous sample-word FIFO. A push into a full FIFO is accepted only when a pop
// happens in the same cycle; pop on empty is ignored.
module audio_word_fifo #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign full    = (level_q == FULL_LEVEL);
    assign empty   = (level_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW + 1)'(1);
                2'b01:   level_q <= level_q - (AW + 1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/iso_in_packetizer.sv
// Isochronous IN audio source: buffers stereo samples and answers each matching IN token
// with one DATA0 packet of whole samples. Define PKT_SILENCE_FILL_EN to zero-pad to full size.
module iso_in_packetizer
    import usb_audio_pkg::*;
#(
    parameter logic [3:0]  EP_NUM        = 4'd1,
    parameter int unsigned FIFO_DEPTH    = 128,
    parameter int unsigned MAX_PKT_WORDS = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  dev_addr,
    input  logic [23:0] token_in,
    input  logic        token_in_strb,
    input  logic [31:0] sample_in,
    input  logic        sample_strb,
    output logic [7:0]  tx_data,
    output logic        tx_strb,
    input  logic        tx_nxt,
    output logic        tx_start_stop,
    input  logic        tx_fail,
    output logic [7:0]  tx_pid,
    output logic [7:0]  fifo_level,
    output logic        overflow
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned LEN_W = $clog2(MAX_PKT_WORDS + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_WORDS);

    pkt_state_e        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  real_q, real_d;  // words still to be taken from the FIFO
    logic [1:0]        idx_q, idx_d;
    logic              overflow_q;

    logic [31:0]       head_word;
    logic [LVL_W-1:0]  lvl;
    logic [31:0]       lvl_wide;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic              token_match;
    logic [LEN_W-1:0]  snap_len;
    logic              unused_fifo_empty;
    logic [4:0]        unused_crc;

    assign unused_fifo_empty = fifo_empty;
    assign unused_crc        = token_in[4:0];

    audio_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (sample_strb),
        .wdata (sample_in),
        .pop   (fifo_pop),
        .rdata (head_word),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (lvl)
    );

    assign lvl_wide   = 32'(lvl);
    assign fifo_level = (lvl_wide > 32'd255) ? 8'hFF : lvl_wide[7:0];
    assign snap_len   = (lvl_wide >= 32'(MAX_PKT_WORDS)) ? MAX_LEN : LEN_W'(lvl);
    assign tx_pid     = PID_DATA0;
    assign overflow   = overflow_q;

    assign token_match = token_in_strb
        && (token_in[TOK_PID_LSB +: TOK_PID_W] == PID_IN)
        && (token_in[TOK_ADDR_LSB +: TOK_ADDR_W] == dev_addr)
        && (token_in[TOK_ENDP_LSB +: TOK_ENDP_W] == EP_NUM);

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        real_d        = real_q;
        idx_d         = idx_q;
        fifo_pop      = 1'b0;
        tx_strb       = 1'b0;
        tx_start_stop = 1'b0;
        tx_data       = 8'h00;
        unique case (state_q)
            StIdle: begin
                if (token_match) begin
`ifdef PKT_SILENCE_FILL_EN
                    len_d = MAX_LEN;
`else
                    len_d = snap_len;
`endif
                    real_d  = snap_len;
                    idx_d   = 2'd0;
                    state_d = StStart;
                end
            end
            StStart: begin
                tx_start_stop = 1'b1;
                idx_d         = 2'd0;
                if (tx_fail)             state_d = StIdle;
                else if (len_q == '0)    state_d = StStop;
                else                     state_d = StData;
            end
            StData: begin
                tx_strb = 1'b1;
                // Silence words follow the real ones and are sent as zeros without popping.
                tx_data = (real_q != '0) ? head_word[{idx_q, 3'b000} +: 8] : 8'h00;
                if (tx_fail) begin
                    idx_d   = 2'd0;
                    state_d = StIdle;
                end else if (tx_nxt) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        len_d = len_q - LEN_W'(1);
                        if (real_q != '0) begin
                            fifo_pop = 1'b1;
                            real_d   = real_q - LEN_W'(1);
                        end
                        if (len_q == LEN_W'(1)) state_d = StStop;
                    end
                end
            end
            StStop: begin
                tx_start_stop = 1'b1;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            len_q      <= '0;
            real_q     <= '0;
            idx_q      <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            real_q  <= real_d;
            idx_q   <= idx_d;
            if (sample_strb && fifo_full && !fifo_pop) overflow_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_iso_in_packetizer.sv
// Scoreboard bench for iso_in_packetizer: a queue-based FIFO/packet model builds expected
// bytes at token time; a negedge monitor compares every cycle of DUT output against it.
module tb_iso_in_packetizer;

    localparam int unsigned DEPTH    = 128;
    localparam int unsigned MAXW     = 48;
    localparam logic [6:0]  DEV_ADDR = 7'h2A;
    localparam logic [7:0]  P_IN     = 8'h69;
    localparam logic [7:0]  P_OUT    = 8'hE1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] token_in = '0;
    logic        token_in_strb = 1'b0;
    logic [31:0] sample_in = '0;
    logic        sample_strb = 1'b0;
    logic        tx_nxt = 1'b0;
    logic        tx_fail = 1'b0;
    logic [7:0]  tx_data, tx_pid, fifo_level;
    logic        tx_strb, tx_start_stop, overflow;

    iso_in_packetizer dut (
        .clk           (clk),
        .rst           (rst),
        .dev_addr      (DEV_ADDR),
        .token_in      (token_in),
        .token_in_strb (token_in_strb),
        .sample_in     (sample_in),
        .sample_strb   (sample_strb),
        .tx_data       (tx_data),
        .tx_strb       (tx_strb),
        .tx_nxt        (tx_nxt),
        .tx_start_stop (tx_start_stop),
        .tx_fail       (tx_fail),
        .tx_pid        (tx_pid),
        .fifo_level    (fifo_level),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents, expected packet bytes and packet phase.
    typedef enum int {PhIdle, PhStart, PhData, PhStop} ph_e;
    ph_e         phase = PhIdle;
    logic [31:0] mq[$];
    logic [7:0]  exp_bytes[$];
    int          real_words = 0;
    int          bcnt = 0;
    logic        overflow_exp = 1'b0;

    always @(negedge clk) begin
        bit          was_idle;
        int          n;
        logic [31:0] w;
        if (rst) begin
            check("rst_tx_strb", tx_strb, 0);
            check("rst_tx_start_stop", tx_start_stop, 0);
            check("rst_tx_data", tx_data, 0);
            check("rst_level", fifo_level, 0);
            check("rst_overflow", overflow, 0);
            mq.delete();
            exp_bytes.delete();
            phase = PhIdle;
            overflow_exp = 1'b0;
            bcnt = 0;
            real_words = 0;
        end else begin
            check("fifo_level", fifo_level, mq.size());
            check("overflow", overflow, overflow_exp);
            check("tx_pid", tx_pid, 8'hC3);
            was_idle = (phase == PhIdle);
            case (phase)
                PhIdle: begin
                    check("idle_tx_strb", tx_strb, 0);
                    check("idle_start_stop", tx_start_stop, 0);
                end
                PhStart: begin
                    check("start_pulse", tx_start_stop, 1);
                    check("start_tx_strb", tx_strb, 0);
                    if (tx_fail) begin
                        exp_bytes.delete();
                        phase = PhIdle;
                    end else begin
                        phase = (exp_bytes.size() == 0) ? PhStop : PhData;
                    end
                end
                PhData: begin
                    check("data_tx_strb", tx_strb, 1);
                    check("data_start_stop", tx_start_stop, 0);
                    if (exp_bytes.size() > 0) check("data_byte", tx_data, exp_bytes[0]);
                    if (tx_fail) begin
                        exp_bytes.delete();
                        phase = PhIdle;
                    end else if (tx_nxt) begin
                        void'(exp_bytes.pop_front());
                        bcnt++;
                        if ((bcnt % 4 == 0) && real_words > 0) begin
                            void'(mq.pop_front());
                            real_words--;
                        end
                        if (exp_bytes.size() == 0) phase = PhStop;
                    end
                end
                PhStop: begin
                    check("stop_pulse", tx_start_stop, 1);
                    check("stop_tx_strb", tx_strb, 0);
                    phase = PhIdle;
                end
                default: phase = PhIdle;
            endcase
            if (was_idle && token_in_strb && token_in[23:16] == P_IN
                && token_in[15:9] == DEV_ADDR && token_in[8:5] == 4'd1) begin
                n = (mq.size() < MAXW) ? mq.size() : MAXW;
                real_words = n;
                bcnt = 0;
                for (int i = 0; i < n; i++) begin
                    w = mq[i];
                    for (int b = 0; b < 4; b++) exp_bytes.push_back(w[8*b +: 8]);
                end
`ifdef PKT_SILENCE_FILL_EN
                for (int i = n; i < MAXW; i++)
                    for (int b = 0; b < 4; b++) exp_bytes.push_back(8'h00);
`endif
                phase = PhStart;
            end
            if (sample_strb) begin
                if (mq.size() < DEPTH) mq.push_back(sample_in);
                else overflow_exp = 1'b1;
            end
        end
    end

    // Stimulus side.
    int nxt_mode = 0;  // 0: tx_nxt=1, 1: toggle, 2: random, 3: driven manually

    task automatic cycle();
        @(posedge clk);
        #1;
        token_in_strb = 1'b0;
        sample_strb   = 1'b0;
        tx_fail       = 1'b0;
        case (nxt_mode)
            0: tx_nxt = 1'b1;
            1: tx_nxt = ~tx_nxt;
            2: tx_nxt = 1'($urandom_range(0, 1));
            default: ;
        endcase
    endtask

    task automatic push_sample(input logic [31:0] w);
        sample_in   = w;
        sample_strb = 1'b1;
        cycle();
    endtask

    task automatic send_token(input logic [7:0] pid, input logic [6:0] addr, input logic [3:0] ep);
        token_in      = {pid, addr, ep, 5'($urandom)};
        token_in_strb = 1'b1;
        cycle();
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (!(phase == PhIdle && exp_bytes.size() == 0) && k < budget) begin
            cycle();
            k++;
        end
        checks++;
        if (k >= budget) begin
            failures++;
            $display("FAIL timeout_%s: packet still open after %0d cycles", name, budget);
        end
    endtask

    task automatic wait_data(input int budget, input string name);
        int k = 0;
        while (phase != PhData && k < budget) begin
            cycle();
            k++;
        end
        checks++;
        if (k >= budget) begin
            failures++;
            $display("FAIL timeout_%s: no data phase within %0d cycles", name, budget);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Three known samples, tx_nxt held high.
        nxt_mode = 0;
        tx_nxt   = 1'b1;
        push_sample(32'h2222_1111);
        push_sample(32'h4444_3333);
        push_sample(32'h6666_5555);
        send_token(P_IN, DEV_ADDR, 4'd1);
        wait_idle(300, "three_words");
        check("three_words_level", fifo_level, 0);

        // Empty FIFO.
        send_token(P_IN, DEV_ADDR, 4'd1);
        wait_idle(400, "empty");

        // 60 samples, tx_nxt toggling: 48 words go, 12 remain.
        for (int i = 0; i < 60; i++) push_sample($urandom);
        nxt_mode = 1;
        send_token(P_IN, DEV_ADDR, 4'd1);
        wait_idle(1000, "sixty");
        check("sixty_level", fifo_level, 12);

        // Non-matching tokens, then a second token while in DATA.
        nxt_mode = 3;
        tx_nxt   = 1'b0;
        send_token(P_IN, DEV_ADDR, 4'd2);
        send_token(P_IN, DEV_ADDR ^ 7'h01, 4'd1);
        send_token(P_OUT, DEV_ADDR, 4'd1);
        repeat (3) cycle();
        check("bad_token_level", fifo_level, 12);
        send_token(P_IN, DEV_ADDR, 4'd1);
        wait_data(10, "second_token");
        send_token(P_IN, DEV_ADDR, 4'd1);
        nxt_mode = 0;
        wait_idle(400, "second_token");

        // Fill to capacity and overflow, then pop and push in the same cycle.
        for (int i = 0; i < DEPTH + 1; i++) push_sample($urandom);
        check("full_level", fifo_level, DEPTH);
        check("full_overflow", overflow, 1);
        nxt_mode = 3;
        tx_nxt   = 1'b0;
        send_token(P_IN, DEV_ADDR, 4'd1);
        wait_data(10, "full_pkt");
        tx_nxt = 1'b1;
        repeat (3) cycle();
        sample_in   = $urandom;
        sample_strb = 1'b1;
        cycle();
        tx_nxt = 1'b0;
        check("push_pop_level", fifo_level, DEPTH);

        // Asynchronous reset in the middle of DATA.
        tx_nxt = 1'b1;
        repeat (5) cycle();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_tx_strb", tx_strb, 0);
        check("async_rst_tx_data", tx_data, 0);
        check("async_rst_start_stop", tx_start_stop, 0);
        check("async_rst_level", fifo_level, 0);
        check("async_rst_overflow", overflow, 0);
        tx_nxt = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;

        // Abort after 6 bytes of a 2-word packet; the retry resends word two.
        push_sample($urandom);
        push_sample($urandom);
        send_token(P_IN, DEV_ADDR, 4'd1);
        wait_data(10, "fail_pkt");
        tx_nxt = 1'b1;
        repeat (6) cycle();
        tx_nxt  = 1'b0;
        tx_fail = 1'b1;
        cycle();
        cycle();
        check("fail_level", fifo_level, 1);
        nxt_mode = 0;
        send_token(P_IN, DEV_ADDR, 4'd1);
        wait_idle(400, "retry");
        check("retry_level", fifo_level, 0);

        // Random traffic.
        nxt_mode = 2;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                sample_in   = $urandom;
                sample_strb = 1'b1;
            end
            if ($urandom_range(0, 39) == 0) begin
                token_in = {($urandom_range(0, 3) == 0) ? P_OUT : P_IN,
                            ($urandom_range(0, 5) == 0) ? 7'($urandom) : DEV_ADDR,
                            ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd1,
                            5'($urandom)};
                token_in_strb = 1'b1;
            end
            if (!tx_nxt && $urandom_range(0, 299) == 0) tx_fail = 1'b1;
            cycle();
        end
        nxt_mode = 0;
        wait_idle(500, "random_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
